// File: rtl/ber_checker_pkg.sv
// Shared definitions for the bit-error-rate checker: FSM encoding,
// default frame geometry and the reference pattern held in the external ROM.
package ber_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } ber_state_e;

  localparam int BER_N     = 48;
  localparam int BER_LOG2N = 6;
  localparam int BER_TW    = 16;

  // Bit i of this vector is pattern bit i (bit 0 is the first bit of a frame).
  // Pattern in transmit order: 1001100100000110010011111100101011111100111011 11
  localparam logic [BER_N-1:0] BER_REF_PATTERN = 48'hF73F_53F2_6099;

endpackage

// File: rtl/ber_sat_accum.sv
// Saturating accumulator: adds inc to total when en is high and clamps at
// the all-ones value of the total width.
module ber_sat_accum #(
  parameter int W  = 16,
  parameter int IW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [IW-1:0] inc,
  output logic [W-1:0]  total
);

  // One guard bit above the wider operand so the raw sum never overflows.
  localparam int SW = ((W > IW) ? W : IW) + 1;

  logic [SW-1:0] sum;
  logic [SW-1:0] max_val;

  assign sum     = SW'(total) + SW'(inc);
  assign max_val = SW'({W{1'b1}});

  // Accumulate, clamping to the maximum representable total.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total <= '0;
    end else if (en) begin
      total <= (sum > max_val) ? '1 : sum[W-1:0];
    end
  end

endmodule

// File: rtl/ber_checker.sv
// Bit-error-rate checker: compares each accepted received bit against a
// reference pattern read from an external ROM, reports per-frame errors and
// keeps saturating totals of errors and frames.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start; in_ready low
// ST_RUN   | accepting bits; idx addresses the ROM for the next bit
// ST_FLUSH | one cycle for the last ROM read to meet the last delayed bit
module ber_checker
  import ber_checker_pkg::*;
#(
  parameter int N     = BER_N,
  parameter int log2N = BER_LOG2N,
  parameter int TW    = BER_TW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic [log2N-1:0] ref_addr,
  output logic             ref_we,
  input  logic             ref_data,
  output logic [log2N-1:0] err_count,
  output logic             frame_done,
  output logic [TW-1:0]    total_err,
  output logic [TW-1:0]    total_frames,
  output logic             busy
);

  localparam logic [log2N-1:0] LAST_IDX = log2N'(N - 1);

  ber_state_e       state;
  ber_state_e       state_next;
  logic             accept;
  logic             last_accept;
  logic             frame_end;
  logic             bit_d;
  logic             cmp_v;
  logic             mismatch;
  logic [log2N-1:0] idx;
  logic [log2N-1:0] count;
  logic [log2N-1:0] count_next;

  // Derived from the state register directly so nothing loops through in_ready.
  assign accept      = in_valid && (state == ST_RUN);
  assign last_accept = accept && (idx == LAST_IDX);
  assign frame_end   = (state == ST_FLUSH);

  assign ref_addr = idx;
  assign ref_we   = 1'b0;

  // State register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and state-derived handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last_accept) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        busy       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Bit index / ROM address: cleared when a frame is armed, held at the last
  // position rather than wrapping.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      idx <= '0;
    end else if ((state == ST_IDLE) && start) begin
      idx <= '0;
    end else if (accept && (idx != LAST_IDX)) begin
      idx <= idx + 1'b1;
    end
  end

  // Stage 1: delay the accepted bit one cycle to line up with ROM read data.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      bit_d <= 1'b0;
      cmp_v <= 1'b0;
    end else begin
      cmp_v <= accept;
      if (accept) bit_d <= in_bit;
    end
  end

  assign mismatch   = cmp_v && (bit_d != ref_data);
  assign count_next = count + log2N'(mismatch);

  // Stage 2: running error count; the final compare lands during FLUSH.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      count <= '0;
    end else if (frame_end) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  // Frame result: err_count and frame_done change together and err_count
  // holds until the next frame completes.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      err_count  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) err_count <= count_next;
    end
  end

  ber_sat_accum #(
    .W  (TW),
    .IW (log2N)
  ) u_total_err (
    .clk   (clk),
    .rst   (rst_n),
    .en    (frame_end),
    .inc   (count_next),
    .total (total_err)
  );

  ber_sat_accum #(
    .W  (TW),
    .IW (1)
  ) u_total_frames (
    .clk   (clk),
    .rst   (rst_n),
    .en    (frame_end),
    .inc   (1'b1),
    .total (total_frames)
  );

endmodule

// File: tb/tb_ber_checker.sv
// Directed bench for ber_checker: a 16-bit-total instance and a 4-bit-total
// instance share stimulus; each has its own one-cycle-latency ROM model.
module tb_ber_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;

  logic        in_ready16, ref_we16, ref_data16, frame_done16, busy16;
  logic [5:0]  ref_addr16, err_count16;
  logic [15:0] total_err16, total_frames16;

  logic        in_ready4, ref_we4, ref_data4, frame_done4, busy4;
  logic [5:0]  ref_addr4, err_count4;
  logic [3:0]  total_err4, total_frames4;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  logic [47:0] pat_vec;
  string       pat_str = "100110010000011001001111110010101111110011101111";

  always #5 clk = ~clk;

  ber_checker dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready16), .ref_addr(ref_addr16), .ref_we(ref_we16), .ref_data(ref_data16),
    .err_count(err_count16), .frame_done(frame_done16), .total_err(total_err16),
    .total_frames(total_frames16), .busy(busy16)
  );

  ber_checker #(.N(48), .log2N(6), .TW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready4), .ref_addr(ref_addr4), .ref_we(ref_we4), .ref_data(ref_data4),
    .err_count(err_count4), .frame_done(frame_done4), .total_err(total_err4),
    .total_frames(total_frames4), .busy(busy4)
  );

  // ROM models: read data valid one cycle after the address.
  always @(posedge clk) begin
    ref_data16 <= (ref_addr16 < 6'd48) ? pat_vec[ref_addr16] : 1'b0;
    ref_data4  <= (ref_addr4 < 6'd48) ? pat_vec[ref_addr4] : 1'b0;
  end

  always @(negedge clk) begin
    if (frame_done16) done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  // Drives one frame. lat counts negedges after the last accept edge until
  // frame_done is seen (2 when the pulse follows the flush edge).
  task automatic run_frame(input logic [47:0] bits, input int nbits, input bit gap,
                           input bit start_mid, input bit do_start, output int lat);
    lat = -1;
    if (do_start) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      if (start_mid && i == 11) check_val("idx_after_start_in_run", 32'(ref_addr16), 32'd11);
      in_valid = 1'b1;
      in_bit   = bits[i];
      start    = start_mid && (i == 10);
      if (gap && i < nbits - 1) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_bit   = ~bits[i];
        start    = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = (nbits == 48) && start_mid;
    if (nbits == 48) begin
      for (int k = 1; k <= 8; k++) begin
        if (frame_done16) begin
          lat = k;
          break;
        end
        @(negedge clk);
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  logic [47:0] frame;
  int lat;
  int done_base;

  initial begin
    for (int i = 0; i < 48; i++) pat_vec[i] = (pat_str[i] == 8'h31);

    // Reset state.
    repeat (3) @(negedge clk);
    check_val("rst_in_ready", 32'(in_ready16), 32'd0);
    check_val("rst_busy", 32'(busy16), 32'd0);
    check_val("rst_frame_done", 32'(frame_done16), 32'd0);
    check_val("rst_err_count", 32'(err_count16), 32'd0);
    check_val("rst_total_err", 32'(total_err16), 32'd0);
    check_val("rst_total_frames", 32'(total_frames16), 32'd0);
    check_val("rst_ref_addr", 32'(ref_addr16), 32'd0);
    check_val("ref_we", 32'(ref_we16), 32'd0);
    rst_n = 1'b0;

    // in_valid while idle is ignored.
    in_valid = 1'b1;
    in_bit   = 1'b1;
    repeat (3) @(negedge clk);
    check_val("idle_ref_addr", 32'(ref_addr16), 32'd0);
    check_val("idle_in_ready", 32'(in_ready16), 32'd0);
    in_valid = 1'b0;

    // Pattern frame, continuous valid.
    done_base = done_cnt;
    run_frame(pat_vec, 48, 1'b0, 1'b0, 1'b1, lat);
    repeat (3) @(negedge clk);
    check_val("pat_latency", 32'(lat), 32'd2);
    check_val("pat_err", 32'(err_count16), 32'd0);
    check_val("pat_frames", 32'(total_frames16), 32'd1);
    check_val("pat_total_err", 32'(total_err16), 32'd0);
    check_val("pat_done_pulses", 32'(done_cnt - done_base), 32'd1);

    // All-zero then all-ones frames from a fresh reset.
    apply_reset();
    check_val("rst2_frames", 32'(total_frames16), 32'd0);
    frame = '0;
    run_frame(frame, 48, 1'b0, 1'b0, 1'b1, lat);
    repeat (3) @(negedge clk);
    check_val("zero_err", 32'(err_count16), 32'd28);
    check_val("zero_total_err", 32'(total_err16), 32'd28);
    repeat (5) @(negedge clk);
    check_val("zero_err_hold", 32'(err_count16), 32'd28);
    frame = '1;
    run_frame(frame, 48, 1'b0, 1'b0, 1'b1, lat);
    repeat (3) @(negedge clk);
    check_val("ones_latency", 32'(lat), 32'd2);
    check_val("ones_err", 32'(err_count16), 32'd20);
    check_val("ones_total_err", 32'(total_err16), 32'd48);
    check_val("ones_frames", 32'(total_frames16), 32'd2);

    // Pattern with bits 0 and 47 flipped, valid toggling.
    frame = pat_vec;
    frame[0]  = ~frame[0];
    frame[47] = ~frame[47];
    run_frame(frame, 48, 1'b1, 1'b0, 1'b1, lat);
    repeat (3) @(negedge clk);
    check_val("gap_latency", 32'(lat), 32'd2);
    check_val("gap_err", 32'(err_count16), 32'd2);
    check_val("gap_total_err", 32'(total_err16), 32'd50);
    check_val("gap_frames", 32'(total_frames16), 32'd3);

    // start pulsed during RUN and during FLUSH.
    done_base = done_cnt;
    run_frame(pat_vec, 48, 1'b0, 1'b1, 1'b1, lat);
    repeat (4) @(negedge clk);
    check_val("start_ign_err", 32'(err_count16), 32'd0);
    check_val("start_ign_done_pulses", 32'(done_cnt - done_base), 32'd1);
    check_val("start_ign_busy", 32'(busy16), 32'd0);
    check_val("start_ign_frames", 32'(total_frames16), 32'd4);

    // Reset after 20 accepts aborts the frame.
    done_base = done_cnt;
    run_frame(pat_vec, 20, 1'b0, 1'b0, 1'b1, lat);
    check_val("partial_ref_addr", 32'(ref_addr16), 32'd20);
    #2 rst_n = 1'b1;
    #1;
    check_val("abort_in_ready", 32'(in_ready16), 32'd0);
    check_val("abort_busy", 32'(busy16), 32'd0);
    check_val("abort_frame_done", 32'(frame_done16), 32'd0);
    check_val("abort_err_count", 32'(err_count16), 32'd0);
    check_val("abort_total_err", 32'(total_err16), 32'd0);
    check_val("abort_total_frames", 32'(total_frames16), 32'd0);
    check_val("abort_ref_addr", 32'(ref_addr16), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("start_first_edge_busy", 32'(busy16), 32'd1);
    check_val("abort_no_done", 32'(done_cnt - done_base), 32'd0);
    run_frame(pat_vec, 48, 1'b0, 1'b0, 1'b0, lat);
    repeat (3) @(negedge clk);
    check_val("post_abort_latency", 32'(lat), 32'd2);
    check_val("post_abort_err", 32'(err_count16), 32'd0);
    check_val("post_abort_frames", 32'(total_frames16), 32'd1);

    // Sixteen all-zero frames: narrow totals saturate.
    apply_reset();
    frame = '0;
    for (int f = 0; f < 16; f++) begin
      run_frame(frame, 48, 1'b0, 1'b0, 1'b1, lat);
      repeat (2) @(negedge clk);
    end
    check_val("sat16_total_err", 32'(total_err16), 32'd448);
    check_val("sat16_frames", 32'(total_frames16), 32'd16);
    check_val("sat4_total_err", 32'(total_err4), 32'd15);
    check_val("sat4_frames", 32'(total_frames4), 32'd15);
    check_val("sat4_err_count", 32'(err_count4), 32'd28);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ber_checker.md
BER_CHECKER -- requirements
Module: ber_checker

Interface
REQ-001 Parameter N, default 48, is the number of bits per frame and the reference-pattern depth.
REQ-002 Parameter log2N, default 6, is the width of the address and per-frame error count.
REQ-003 Parameter TW, default 16, is the width of the cumulative error and frame counters.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous reset, active-high; it asserts on the rising edge of rst_n.
REQ-006 Port start, input, 1 bit: one-cycle pulse that arms a new frame.
REQ-007 Port in_valid, input, 1 bit: a received demodulated bit is present on in_bit.
REQ-008 Port in_bit, input, 1 bit: the received bit.
REQ-009 Port in_ready, output, 1 bit: high only in RUN; a bit is accepted when in_valid and in_ready are both high.
REQ-010 Port ref_addr, output, log2N bits: read address to the reference-pattern ROM.
REQ-011 Port ref_we, output, 1 bit: tied to 0, so the ROM is always in read mode.
REQ-012 Port ref_data, input, 1 bit: ROM read data, valid one cycle after ref_addr is presented.
REQ-013 Port err_count, output, log2N bits: bit-error count of the last completed frame.
REQ-014 Port frame_done, output, 1 bit: one-cycle pulse; err_count is updated in the same cycle.
REQ-015 Port total_err, output, TW bits: cumulative errors since reset, saturating.
REQ-016 Port total_frames, output, TW bits: completed frames since reset, saturating.
REQ-017 Port busy, output, 1 bit: high in RUN and FLUSH.

Function
REQ-018 The FSM shall have three states: IDLE, RUN and FLUSH.
- IDLE -> RUN on start.
- RUN -> FLUSH on the Nth accept.
- FLUSH -> IDLE after one cycle.
REQ-019 start outside IDLE shall be ignored; start on the same edge as reset shall be ignored.
REQ-020 ref_addr shall equal the index register idx (0..N-1), driven from a register with no combinational input path.
- idx clears on entry to RUN.
- idx increments on each accept.
- idx shall not wrap inside a frame.
REQ-021 Stage 1: each accept shall register in_bit and a compare-valid flag, aligning the bit with ref_data one cycle later.
REQ-022 Stage 2: when compare-valid is high, the running count shall add 1 if the delayed bit differs from ref_data.
REQ-023 The last compare shall land in FLUSH. On that edge, err_count shall load the final count and frame_done shall pulse on the following cycle.
- Latency: frame_done is high exactly 2 cycles after the Nth accept edge.
REQ-024 On the same edge as REQ-023:
- total_err adds the frame count, saturating at 2^TW-1.
- total_frames adds 1, saturating at 2^TW-1.
- The running count clears.
REQ-025 Gaps in in_valid during RUN shall stall idx and the comparison without any error being counted.
REQ-026 in_valid while in_ready is low shall be ignored; the bit is not counted.
REQ-027 err_count shall hold its value until the next frame_done.

Reset
REQ-028 Reset shall immediately return the block to IDLE and set every output low or to zero (in_ready, busy, frame_done, err_count, total_err, total_frames, ref_addr), aborting any partial frame without a frame_done pulse.
REQ-029 After reset is released, the block shall accept start on the first clock edge.

Structure
REQ-030 A shared package shall hold:
- the FSM state encoding;
- the N and log2N defaults;
- the 48-bit reference pattern, bits 0..47 = 1001100100000110010011111100101011111100111011 11 (the final 11 are bits 46..47).
REQ-031 The saturating accumulators for total_err and total_frames shall be one sub-module, ber_sat_accum, instantiated twice; everything else is inline.

Verification
REQ-032 Frame equal to the pattern, in_valid continuous -> err_count=0; frame_done 2 cycles after the 48th accept; total_frames=1.
REQ-033 All-zero frame -> err_count=28; all-ones frame next -> err_count=20, total_err=48, total_frames=2.
REQ-034 Pattern with bits 0 and 47 flipped, in_valid toggling 1-0-1 -> err_count=2; no bit lost or double-counted.
REQ-035 Start pulsed during RUN and during FLUSH -> ignored: idx unchanged, a single frame_done.
REQ-036 rst_n asserted after 20 accepts -> all outputs 0 and no frame_done; a following full pattern frame -> err_count=0, total_frames=1.
REQ-037 With TW=4, 16 all-zero frames -> total_err=15 and total_frames=15, both saturated.
